// File: rtl/cim_bitserial_mac.sv
// rtl/cim_bitserial_mac.sv - bit-serial compute-in-memory MAC with per-channel scale
// Activations are consumed one bit plane per cycle, optionally skipping all-zero planes.
module cim_bitserial_mac #(
  parameter int NUM_INPUTS = 8,
  parameter int WT_BITS    = 8,
  parameter int ACT_BITS   = 4,
  parameter int NUM_CH     = 2,
  parameter int SCALE_BITS = 4,
  localparam int ACC_W = WT_BITS + ACT_BITS + $clog2(NUM_INPUTS),
  localparam int OUT_W = ACC_W + SCALE_BITS,
  localparam int CNT_W = $clog2(ACT_BITS + 1)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [NUM_INPUTS-1:0][ACT_BITS-1:0]            act,
  input  logic [NUM_CH-1:0][NUM_INPUTS-1:0][WT_BITS-1:0] wt,
  input  logic [NUM_CH-1:0][SCALE_BITS-1:0]              scale,
  input  logic                                           scale_bypass,
  input  logic                                           skip_en,
  input  logic                                           flush,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [NUM_CH-1:0][OUT_W-1:0]                   out_data,
  output logic [CNT_W-1:0]                               planes_used,
  output logic                                           act_zero,
  output logic                                           busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

  localparam logic [ACT_BITS-1:0] PLANE_ONE = ACT_BITS'(1);

  state_t state, state_nxt;

  logic [NUM_INPUTS-1:0][ACT_BITS-1:0]            act_r;
  logic [NUM_CH-1:0][NUM_INPUTS-1:0][WT_BITS-1:0] wt_r;
  logic [NUM_CH-1:0][SCALE_BITS-1:0]              scale_r;
  logic                                           bypass_r;
  logic [ACT_BITS-1:0]                            mask;
  logic [NUM_CH-1:0][ACC_W-1:0]                   acc;

  logic [ACT_BITS-1:0]                act_or;
  logic [ACT_BITS-1:0]                mask_in;
  logic [ACT_BITS-1:0]                mask_rest;
  logic                               accept;
  logic                               last_plane;
  logic                               found;
  logic [CNT_W-1:0]                   sel_b;
  logic [NUM_INPUTS-1:0]              plane_bits;
  logic [NUM_CH-1:0][ACC_W-1:0]       plane_term;
  logic [NUM_CH-1:0][OUT_W-1:0]       scaled;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign accept    = in_ready & in_valid & ~flush;

  always_comb begin
    act_or = '0;
    for (int i = 0; i < NUM_INPUTS; i++) act_or = act_or | act[i];
    mask_in = skip_en ? act_or : '1;
  end

  // Clearing the lowest set bit leaves nothing when this plane is the last one.
  assign mask_rest  = mask & (mask - PLANE_ONE);
  assign last_plane = (mask_rest == '0);

  always_comb begin
    found      = 1'b0;
    sel_b      = '0;
    plane_bits = '0;
    for (int b = 0; b < ACT_BITS; b++) begin
      if (mask[b] && !found) begin
        found = 1'b1;
        sel_b = CNT_W'(b);
        for (int i = 0; i < NUM_INPUTS; i++) plane_bits[i] = act_r[i][b];
      end
    end
  end

  always_comb begin
    plane_term = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (plane_bits[i])
          plane_term[ch] = plane_term[ch] +
            {{(ACC_W-WT_BITS){wt_r[ch][i][WT_BITS-1]}}, wt_r[ch][i]};
      end
      plane_term[ch] = plane_term[ch] << sel_b;
    end
  end

  // Both operands widened to OUT_W so the signed product is exact.
  always_comb begin
    scaled = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (bypass_r)
        scaled[ch] = {{SCALE_BITS{acc[ch][ACC_W-1]}}, acc[ch]};
      else
        scaled[ch] = OUT_W'($signed({{SCALE_BITS{acc[ch][ACC_W-1]}}, acc[ch]}) *
                            $signed({{ACC_W{1'b0}}, scale_r[ch]}));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (mask_in != '0) ? ACCUM : SCALE;
      ACCUM:   if (last_plane) state_nxt = SCALE;
      SCALE:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_r       <= '0;
      wt_r        <= '0;
      scale_r     <= '0;
      bypass_r    <= 1'b0;
      mask        <= '0;
      acc         <= '0;
      out_data    <= '0;
      planes_used <= '0;
      act_zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            act_r       <= act;
            wt_r        <= wt;
            scale_r     <= scale;
            bypass_r    <= scale_bypass;
            mask        <= mask_in;
            acc         <= '0;
            planes_used <= '0;
            act_zero    <= (act == '0);
          end
        end
        ACCUM: begin
          if (!flush) begin
            for (int ch = 0; ch < NUM_CH; ch++) acc[ch] <= acc[ch] + plane_term[ch];
            mask        <= mask_rest;
            planes_used <= planes_used + CNT_W'(1);
          end
        end
        SCALE: begin
          if (!flush) out_data <= scaled;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_bitserial_mac.sv
// tb/tb_cim_bitserial_mac.sv - directed and randomized bench for cim_bitserial_mac
// Expected results come from a plain integer dot-product model.
module tb_cim_bitserial_mac;
  localparam int NI = 8;
  localparam int WB = 8;
  localparam int AB = 4;
  localparam int NC = 2;
  localparam int SB = 4;
  localparam int OW = WB + AB + $clog2(NI) + SB;
  localparam int CW = $clog2(AB + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [NI-1:0][AB-1:0] act = '0;
  logic [NC-1:0][NI-1:0][WB-1:0] wt = '0;
  logic [NC-1:0][SB-1:0] scale = '0;
  logic scale_bypass = 1'b0;
  logic skip_en = 1'b0;
  logic flush = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [NC-1:0][OW-1:0] out_data;
  logic [CW-1:0] planes_used;
  logic act_zero;
  logic busy;

  int total = 0;
  int bad = 0;
  int act_v[NI];
  int wt_v[NC][NI];
  int scale_v[NC];
  logic skip_v, byp_v;

  cim_bitserial_mac dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .wt(wt), .scale(scale), .scale_bypass(scale_bypass),
    .skip_en(skip_en), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .planes_used(planes_used), .act_zero(act_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_out(input int ch);
    int dot = 0;
    for (int i = 0; i < NI; i++) dot += wt_v[ch][i] * act_v[i];
    return byp_v ? dot : dot * scale_v[ch];
  endfunction

  function automatic int model_planes();
    int orv = 0;
    int n = 0;
    if (!skip_v) return AB;
    for (int i = 0; i < NI; i++) orv |= act_v[i];
    for (int b = 0; b < AB; b++) n += (orv >> b) & 1;
    return n;
  endfunction

  function automatic int model_zero();
    for (int i = 0; i < NI; i++) if (act_v[i] != 0) return 0;
    return 1;
  endfunction

  task automatic set_uniform(input int a, input int w0, input int w1, input int s, input logic sk, input logic by);
    for (int i = 0; i < NI; i++) begin
      act_v[i] = a; wt_v[0][i] = w0; wt_v[1][i] = w1;
    end
    scale_v[0] = s; scale_v[1] = s; skip_v = sk; byp_v = by;
  endtask

  task automatic set_random();
    int keep;
    keep = $urandom_range(0, 15);
    for (int i = 0; i < NI; i++) begin
      act_v[i] = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) act_v[i] &= keep;
      for (int c = 0; c < NC; c++) wt_v[c][i] = int'($urandom_range(0, 255)) - 128;
    end
    for (int c = 0; c < NC; c++) scale_v[c] = $urandom_range(0, 15);
    skip_v = 1'($urandom_range(0, 1));
    byp_v  = 1'($urandom_range(0, 1));
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      act[i] = AB'(act_v[i]);
      for (int c = 0; c < NC; c++) wt[c][i] = WB'(wt_v[c][i]);
    end
    for (int c = 0; c < NC; c++) scale[c] = SB'(scale_v[c]);
    skip_en = skip_v;
    scale_bypass = byp_v;
  endtask

  task automatic scramble();
    act = NI*AB'($urandom);
    wt = {$urandom, $urandom, $urandom, $urandom};
    scale = NC*SB'($urandom);
    skip_en = 1'($urandom);
    scale_bypass = 1'($urandom);
  endtask

  task automatic accept_req();
    @(negedge clk);
    drive();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, model_planes() + 1);
  endtask

  task automatic check_result(input string tag);
    for (int c = 0; c < NC; c++)
      chk($sformatf("%s_out%0d", tag, c), $signed(out_data[c]), model_out(c));
    chk({tag, "_planes"}, planes_used, model_planes());
    chk({tag, "_act_zero"}, act_zero, model_zero());
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, in_ready, 1);
    chk({tag, "_out_valid_after"}, out_valid, 0);
  endtask

  task automatic do_req(input string tag);
    accept_req();
    chk({tag, "_busy"}, busy, 1);
    wait_valid(tag);
    check_result(tag);
    release_out(tag);
  endtask

  initial begin
    logic [NC-1:0][OW-1:0] held;
    logic saw;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data0", $signed(out_data[0]), 0);
    chk("rst_out_data1", $signed(out_data[1]), 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_planes", planes_used, 0);

    set_uniform(1, 1, -1, 3, 1'b1, 1'b0);
    do_req("ones_skip");

    set_uniform(15, -128, -128, 15, 1'b0, 1'b0);
    do_req("max_neg");
    set_uniform(15, -128, -128, 15, 1'b0, 1'b1);
    do_req("max_neg_bypass");

    set_uniform(0, 77, -5, 9, 1'b1, 1'b0);
    do_req("zero_act_skip");
    set_uniform(0, 77, -5, 9, 1'b0, 1'b0);
    do_req("zero_act_noskip");

    set_uniform(15, 127, -128, 15, 1'b1, 1'b0);
    do_req("max_mixed");

    for (int k = 0; k < 24; k++) begin
      set_random();
      do_req($sformatf("rand%0d", k));
    end

    set_uniform(5, 3, -7, 2, 1'b1, 1'b0);
    accept_req();
    wait_valid("stall");
    check_result("stall");
    held = out_data;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      scramble();
      @(posedge clk);
      #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out0", $signed(out_data[0]), $signed(held[0]));
      chk("stall_out1", $signed(out_data[1]), $signed(held[1]));
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out("stall");
    chk("stall_busy_after", busy, 0);

    set_uniform(15, 9, 9, 1, 1'b0, 1'b0);
    accept_req();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      saw = saw | out_valid | busy;
    end
    chk("flush_no_valid", saw, 0);

    @(negedge clk);
    drive();
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_beats_accept", busy, 0);

    set_uniform(3, 11, -2, 7, 1'b0, 1'b0);
    accept_req();
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out0", $signed(out_data[0]), 0);
    chk("mid_rst_out1", $signed(out_data[1]), 0);
    chk("mid_rst_planes", planes_used, 0);
    chk("mid_rst_act_zero", act_zero, 0);
    @(negedge clk);
    reset = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      saw = saw | out_valid;
    end
    chk("mid_rst_no_valid", saw, 0);
    set_random();
    do_req("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cim_bitserial_mac.md
CIM_BITSERIAL_MAC -- requirements
Module: cim_bitserial_mac

Interface
REQ-001 SHALL have parameters (name, default, meaning): NUM_INPUTS, 8, dot-product length (power of 2); WT_BITS, 8, signed weight width; ACT_BITS, 4, unsigned activation width (bit-serial planes); NUM_CH, 2, parallel output channels; SCALE_BITS, 4, unsigned per-channel scale width.
REQ-002 SHALL derive ACC_W = WT_BITS+ACT_BITS+$clog2(NUM_INPUTS), OUT_W = ACC_W+SCALE_BITS and CNT_W = $clog2(ACT_BITS+1).
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- act  in  [NUM_INPUTS][ACT_BITS]  unsigned activations.
- wt  in  [NUM_CH][NUM_INPUTS][WT_BITS]  signed weights.
- scale  in  [NUM_CH][SCALE_BITS]  unsigned per-channel scale.
- scale_bypass  in  1  1 = output the sign-extended accumulator unscaled.
- skip_en  in  1  1 = skip all-zero activation bit planes.
- flush  in  1  synchronous abort to IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  [NUM_CH][OUT_W]  signed results.
- planes_used  out  CNT_W  number of ACCUM cycles spent on the current/last result.
- act_zero  out  1  all activations were zero at acceptance.
- busy  out  1  state != IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, ACCUM, SCALE, OUT.
REQ-005 SHALL assert in_ready only in IDLE, and SHALL accept a request on an edge where in_valid & in_ready & ~flush.
REQ-006 SHALL, on accept, register act, wt, scale, scale_bypass and skip_en, clear all accumulators, clear planes_used, and set act_zero = (all act == 0).
REQ-007 SHALL, on accept, form the pending-plane mask: bit b = OR over i of act[i][b] when skip_en=1, otherwise all ones.
REQ-008 SHALL go from IDLE to ACCUM when the mask is non-zero, and directly to SCALE when it is zero.
REQ-009 SHALL, in each ACCUM cycle, select the lowest set mask bit b, add (sum over i of act[i][b] ? wt[ch][i] : 0) << b, sign-extended to ACC_W, into acc[ch] for every ch, clear mask bit b, and increment planes_used.
REQ-010 SHALL leave ACCUM for SCALE in the cycle after the last set mask bit is consumed; ACCUM SHALL therefore last exactly popcount(mask) cycles.
REQ-011 SHALL, in SCALE, register out_data[ch] = acc[ch] * scale[ch] (signed x unsigned, exact in OUT_W), or the sign-extended acc[ch] when scale_bypass=1, then enter OUT.
REQ-012 SHALL assert out_valid only in OUT, holding out_data, planes_used and act_zero stable until out_valid & out_ready; on that edge it SHALL return to IDLE.
REQ-013 SHALL give latency: out_valid rises popcount(mask)+1 cycles after the accepting edge (ACT_BITS+1 when skip_en=0).
REQ-014 SHALL ignore in_valid and input data outside IDLE.
REQ-015 SHALL let flush force IDLE on the next edge from any state, deassert out_valid and discard partial results; flush SHALL win over a simultaneous accept or output handshake.
REQ-016 SHALL NOT overflow acc or out_data for any input values; saturation logic is not required.

Reset
REQ-017 SHALL, while reset=0, asynchronously force IDLE and clear mask, acc, out_data, planes_used, act_zero, out_valid and busy to 0; in_ready SHALL read 1 from the first edge after reset deasserts.
REQ-018 SHALL treat reset asserted mid-transaction as an abort with no out_valid for that request.

Verification (defaults NUM_INPUTS=8, WT_BITS=8, ACT_BITS=4, NUM_CH=2, SCALE_BITS=4)
REQ-019 SHALL check: reset released -> out_valid=0, busy=0, out_data=0, in_ready=1.
REQ-020 SHALL check: act all 4'd1, wt ch0 all +1, ch1 all -1, scale 3, skip_en=1 -> out_valid 2 cycles after accept, out_data {24, -24}, planes_used=1.
REQ-021 SHALL check: act all 4'd15, wt all -128, scale 15, skip_en=0 -> out_valid 5 cycles after accept, out_data -230400 on both channels, planes_used=4; same stimulus with scale_bypass=1 -> -15360.
REQ-022 SHALL check: act all 0, skip_en=1 -> out_valid 1 cycle after accept, out_data 0, planes_used=0, act_zero=1.
REQ-023 SHALL check: out_ready held low 10 cycles -> out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-024 SHALL check: flush in the 2nd ACCUM cycle -> IDLE next edge with no out_valid; reset pulsed low mid-ACCUM -> all outputs 0 immediately, and a following request produces a correct result.
